// File: rtl/decoder_scan_pkg.sv
// Shared types and code arithmetic for the
// 3-to-8 decoder select-code sequencer.
package decoder_scan_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  localparam int CODE_W = 3;
  localparam logic [CODE_W-1:0] CODE_MAX = 3'd7;

  function automatic logic [CODE_W-1:0] code_next(
    input logic [CODE_W-1:0] c,
    input logic              d
  );
    return (d == DIR_DOWN) ? c - CODE_W'(1)
                           : c + CODE_W'(1);
  endfunction

  function automatic logic code_wraps(
    input logic [CODE_W-1:0] c,
    input logic              d
  );
    return (d == DIR_DOWN) ? (c == '0)
                           : (c == CODE_MAX);
  endfunction

endpackage

// File: rtl/decoder_scan_seq_dwell_timer.sv
// Dwell counter: load, count down to zero,
// then hold there with the zero flag raised.
module dwell_timer #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               en,
  input  logic [DWELL_W-1:0] dwell,
  output logic               zero
);

  logic [DWELL_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= dwell;
    end else if (en && cnt != '0) begin
      cnt <= cnt - DWELL_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/decoder_scan_seq.sv
// Select-code sequencer driving decoder A/B/C:
// free-run, single-sweep and manual step modes.
module decoder_scan_seq
  import decoder_scan_pkg::*;
#(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               step,
  input  logic               dir,
  input  logic               sweep,
  input  logic [DWELL_W-1:0] dwell,
  output logic               A,
  output logic               B,
  output logic               C,
  output logic               busy,
  output logic               wrap,
  output logic               done
);

  state_t            state;
  logic [CODE_W-1:0] code;
  logic [CODE_W-1:0] nxt;
  logic              wraps;
  logic              go;
  logic              adv;
  logic              fin;
  logic              tmr_load;
  logic              tmr_en;
  logic              zero;
  logic [DWELL_W-1:0] tmr_val;

  always_comb begin
    nxt   = code_next(code, dir);
    wraps = code_wraps(code, dir);
    go    = (state == IDLE) && start && !stop;
    adv   = (state == RUN) && !stop && zero;
    fin   = adv && sweep && wraps;
    // stop and sweep-end both leave the counter cleared
    tmr_load = go || (state == RUN && (stop || zero));
    tmr_val  = (go || (adv && !fin)) ? dwell : '0;
    tmr_en   = (state == RUN);
  end

  dwell_timer #(
    .DWELL_W (DWELL_W)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (tmr_load),
    .en    (tmr_en),
    .dwell (tmr_val),
    .zero  (zero)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      code  <= '0;
      busy  <= 1'b0;
      wrap  <= 1'b0;
      done  <= 1'b0;
    end else begin
      wrap <= 1'b0;
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            if (!stop) begin
              state <= RUN;
              busy  <= 1'b1;
            end
          end else if (step) begin
            code <= nxt;
            wrap <= wraps;
          end
        end
        RUN: begin
          if (stop) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (zero) begin
            if (sweep && wraps) begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              code <= nxt;
              wrap <= wraps;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign {A, B, C} = code;

endmodule

// File: tb/tb_decoder_scan_seq.sv
// Self-checking bench for decoder_scan_seq:
// vector table, directed corners, random vs model.
module tb_decoder_scan_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       step = 1'b0;
  logic       dir = 1'b0;
  logic       sweep = 1'b0;
  logic [7:0] dwell = 8'd0;
  logic       A, B, C;
  logic       busy, wrap, done;
  logic [2:0] code;
  logic [7:0] y;

  int errors = 0;
  int checks = 0;

  // Timestamp model: next advance edge number
  int cyc = 0;
  bit m_run = 0;
  int m_code = 0;
  bit m_wrap = 0;
  bit m_done = 0;
  int m_next = 0;

  decoder_scan_seq #(.DWELL_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .stop  (stop),
    .step  (step),
    .dir   (dir),
    .sweep (sweep),
    .dwell (dwell),
    .A     (A),
    .B     (B),
    .C     (C),
    .busy  (busy),
    .wrap  (wrap),
    .done  (done)
  );

  assign code = {A, B, C};
  assign y = 8'b1 << code;

  always #5 clk = ~clk;

  function automatic bit m_wraps();
    return dir ? (m_code == 0) : (m_code == 7);
  endfunction

  task automatic m_step();
    m_wrap = m_wraps();
    m_code = dir ? (m_code + 7) % 8
                 : (m_code + 1) % 8;
  endtask

  task automatic model_edge();
    cyc++;
    m_wrap = 0;
    m_done = 0;
    if (!rst_n) begin
      m_run = 0;
      m_code = 0;
    end else if (!m_run) begin
      if (start) begin
        if (!stop) begin
          m_run = 1;
          m_next = cyc + int'(dwell) + 1;
        end
      end else if (step) begin
        m_step();
      end
    end else if (stop) begin
      m_run = 0;
    end else if (cyc == m_next) begin
      if (sweep && m_wraps()) begin
        m_run = 0;
        m_done = 1;
      end else begin
        m_step();
        m_next = cyc + int'(dwell) + 1;
      end
    end
  endtask

  task automatic edge_t();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_code"}, 32'(code), 32'(m_code));
    chk({tag, "_busy"}, 32'(busy), 32'(m_run));
    chk({tag, "_wrap"}, 32'(wrap), 32'(m_wrap));
    chk({tag, "_done"}, 32'(done), 32'(m_done));
  endtask

  task automatic quiet();
    start = 0;
    stop = 0;
    step = 0;
  endtask

  typedef struct {
    logic       rst_n;
    logic       start;
    logic       stop;
    logic       step;
    logic       dir;
    logic       sweep;
    logic [7:0] dwell;
    int         code;
    logic       busy;
    logic       wrap;
    logic       done;
  } vec_t;

  vec_t tbl[13];

  initial begin
    logic [7:0] one;
    one = 8'h01;

    tbl[0]  = '{0,0,0,0,0,0,8'd3, 0,0,0,0};
    tbl[1]  = '{1,0,0,0,0,0,8'd3, 0,0,0,0};
    tbl[2]  = '{1,0,0,1,0,0,8'd3, 1,0,0,0};
    tbl[3]  = '{1,0,0,1,0,0,8'd3, 2,0,0,0};
    tbl[4]  = '{1,0,0,1,1,0,8'd3, 1,0,0,0};
    tbl[5]  = '{1,0,0,1,1,0,8'd3, 0,0,0,0};
    tbl[6]  = '{1,0,0,1,1,0,8'd3, 7,0,1,0};
    tbl[7]  = '{1,0,0,0,1,0,8'd3, 7,0,0,0};
    tbl[8]  = '{1,0,0,1,0,0,8'd3, 0,0,1,0};
    tbl[9]  = '{1,1,0,1,0,0,8'd3, 0,1,0,0};
    tbl[10] = '{1,0,0,0,0,0,8'd3, 0,1,0,0};
    tbl[11] = '{1,1,1,0,0,0,8'd3, 0,0,0,0};
    tbl[12] = '{1,1,1,0,0,0,8'd3, 0,0,0,0};

    // Reset then idle: all outputs low
    rst_n = 0;
    edge_t();
    rst_n = 1;
    for (int i = 0; i < 5; i++) edge_t();
    chk("rst_code", 32'(code), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_wrap", 32'(wrap), 0);
    chk("rst_done", 32'(done), 0);

    for (int i = 0; i < 13; i++) begin
      rst_n = tbl[i].rst_n;
      start = tbl[i].start;
      stop  = tbl[i].stop;
      step  = tbl[i].step;
      dir   = tbl[i].dir;
      sweep = tbl[i].sweep;
      dwell = tbl[i].dwell;
      edge_t();
      chk($sformatf("tbl%0d_code", i),
          32'(code), 32'(tbl[i].code));
      chk($sformatf("tbl%0d_busy", i),
          32'(busy), 32'(tbl[i].busy));
      chk($sformatf("tbl%0d_wrap", i),
          32'(wrap), 32'(tbl[i].wrap));
      chk($sformatf("tbl%0d_done", i),
          32'(done), 32'(tbl[i].done));
    end
    quiet();
    rst_n = 1;

    // Free run up, dwell 2: change every 3 clocks
    dwell = 8'd2;
    dir = 0;
    sweep = 0;
    start = 1;
    edge_t();
    start = 0;
    for (int j = 1; j <= 24; j++) begin
      edge_t();
      chk($sformatf("run_code%0d", j),
          32'(code), 32'((j / 3) % 8));
      chk($sformatf("run_wrap%0d", j),
          32'(wrap), 32'(j == 24));
    end
    stop = 1;
    edge_t();
    stop = 0;
    chk("run_stop_busy", 32'(busy), 0);

    // Down sweep from 3 with dwell 0
    dir = 0;
    step = 1;
    for (int j = 0; j < 3; j++) edge_t();
    step = 0;
    chk("pre_sweep_code", 32'(code), 3);
    dwell = 8'd0;
    dir = 1;
    sweep = 1;
    start = 1;
    edge_t();
    start = 0;
    chk("sw_start_busy", 32'(busy), 1);
    for (int j = 1; j <= 4; j++) begin
      edge_t();
      chk($sformatf("sw_code%0d", j),
          32'(code), (j < 4) ? 32'(3 - j) : 0);
      chk($sformatf("sw_busy%0d", j),
          32'(busy), 32'(j < 4));
      chk($sformatf("sw_done%0d", j),
          32'(done), 32'(j == 4));
      chk($sformatf("sw_wrap%0d", j), 32'(wrap), 0);
    end
    edge_t();
    chk("sw_done_after", 32'(done), 0);
    chk("sw_code_after", 32'(code), 0);

    // Manual step wrap, then start beats step
    dir = 1;
    step = 1;
    edge_t();
    chk("stp_dn_code", 32'(code), 7);
    dir = 0;
    edge_t();
    chk("stp_up_code", 32'(code), 0);
    chk("stp_up_wrap", 32'(wrap), 1);
    start = 1;
    edge_t();
    chk("ss_code", 32'(code), 0);
    chk("ss_busy", 32'(busy), 1);
    chk("ss_wrap", 32'(wrap), 0);
    quiet();
    stop = 1;
    edge_t();
    stop = 0;

    // start+stop mid-dwell, then reset mid-run
    dwell = 8'd4;
    sweep = 0;
    dir = 0;
    start = 1;
    edge_t();
    start = 0;
    edge_t();
    edge_t();
    start = 1;
    stop = 1;
    edge_t();
    quiet();
    chk("ssp_busy", 32'(busy), 0);
    chk("ssp_code", 32'(code), 0);
    for (int j = 0; j < 6; j++) edge_t();
    chk("ssp_frozen", 32'(code), 0);
    chk("ssp_idle", 32'(busy), 0);
    start = 1;
    edge_t();
    start = 0;
    for (int j = 0; j < 7; j++) edge_t();
    chk("mid_code", 32'(code), 1);
    chk("mid_busy", 32'(busy), 1);
    rst_n = 0;
    edge_t();
    chk("mrst_code", 32'(code), 0);
    chk("mrst_busy", 32'(busy), 0);
    rst_n = 1;
    edge_t();
    chk("mrst_idle", 32'(busy), 0);
    chk("mrst_hold", 32'(code), 0);

    // Decoder scan: one-hot walks bit 0 to bit 7
    dwell = 8'd0;
    sweep = 1;
    dir = 0;
    start = 1;
    edge_t();
    start = 0;
    chk("y0", 32'(y), 32'(one));
    for (int j = 1; j <= 8; j++) begin
      edge_t();
      chk($sformatf("y%0d", j), 32'(y),
          32'(one << ((j < 8) ? j : 7)));
    end
    chk("y_done", 32'(done), 1);
    chk("y_busy", 32'(busy), 0);

    // Random stimulus against the model
    for (int i = 0; i < 600; i++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      start = ($urandom_range(0, 15) == 0);
      stop  = ($urandom_range(0, 31) == 0);
      step  = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 7) == 0)
        dir = ~dir;
      sweep = ($urandom_range(0, 3) == 0);
      dwell = 8'($urandom_range(0, 3));
      edge_t();
      chk_model("rnd");
    end

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/decoder_scan_seq.md
Name: decoder_scan_seq

Overview:
Upstream select-code sequencer for the 3-to-8 decoder.
- Generates the 3-bit code A,B,C (A = MSB) that the decoder turns into a one-hot 8-bit Y.
- Steps the code up or down with a programmable dwell time.
- Supports free-running, single-sweep and manual single-step operation, so the decoder's eight outputs can be scanned without testbench-driven delays.

Parameters:
DWELL_W, 8, width of the dwell count input; the code holds for dwell+1 clocks per step.

Ports:
clk  in  1  system clock; one clock domain, all logic on the rising edge.
rst_n  in  1  reset, synchronous and active-low.
start  in  1  one-clock request to enter RUN from IDLE.
stop  in  1  one-clock request to return to IDLE.
step  in  1  in IDLE, advance the code by one position.
dir  in  1  0 = count up, 1 = count down.
sweep  in  1  0 = continuous wrap, 1 = single sweep then stop.
dwell  in  DWELL_W  hold length; the code is held for dwell+1 clocks.
A  out  1  code bit 2 (MSB), to decoder A.
B  out  1  code bit 1, to decoder B.
C  out  1  code bit 0, to decoder C.
busy  out  1  high while in RUN.
wrap  out  1  one-clock pulse on a 7->0 (up) or 0->7 (down) transition.
done  out  1  one-clock pulse when a single sweep ends.

Behaviour:
- Reset (rst_n = 0 at an edge):
  - state = IDLE; code = 000, so A = B = C = 0.
  - cnt = 0; busy = wrap = done = 0.
  - Reset overrides everything, including mid-RUN.
- All outputs are registered. A,B,C are always driven from the code register.
- State IDLE:
  - start -> RUN; cnt <= dwell; busy = 1 from the next cycle.
  - step (with start = 0) -> advance the code by one in direction dir, one-cycle latency. wrap pulses if the advance wraps. Stays in IDLE.
  - Otherwise hold.
- State RUN, evaluated each cycle:
  - If cnt != 0: cnt <= cnt - 1.
  - If cnt == 0: advance the code and reload cnt <= dwell.
  - Period: start sampled at edge k gives the first code change at edge k+dwell+1, then one change every dwell+1 clocks. With dwell = 0 the code changes every clock.
  - dir and dwell are sampled at each advance/reload. A change mid-dwell takes effect at the next advance.
  - step is ignored in RUN.
- Advance arithmetic: 3-bit modulo-8. Up: code+1, 7 -> 0. Down: code-1, 0 -> 7. wrap = 1 in the cycle the wrapped code appears.
- Single sweep (sweep = 1 in RUN):
  - An advance that would wrap is suppressed: the code holds at its terminal value (7 up / 0 down).
  - The block goes to IDLE, done pulses for one cycle, busy drops in that same cycle, and wrap does not pulse.
  - sweep = 0: wrap continuously.
- Simultaneous events:
  - start and stop together: stop wins, block stays or goes IDLE.
  - stop in RUN: next cycle IDLE, busy = 0, code holds, cnt cleared, no advance in the stop cycle.
  - start while already in RUN: ignored.
  - step together with start in IDLE: start wins, no step.
- No combinational path from any input to any output.

Decomposition:
- Package decoder_scan_pkg:
  - state enum {IDLE, RUN}
  - DIR_UP = 1'b0, DIR_DOWN = 1'b1
  - CODE_W = 3, CODE_MAX = 3'd7
- Sub-module dwell_timer (DWELL_W): holds the load/decrement/zero-flag counter.
  - Ports: clk, rst_n, load, en, dwell, zero.
  - Instantiated once.
- Top-level sequencer holds the state machine and the code register. It feeds decoder_3_to_8_df directly in the system bench.

Test Plan:
- Reset, then idle 5 clocks -> A,B,C = 000, busy = wrap = done = 0.
- dwell = 2, dir = 0, sweep = 0, pulse start at edge k -> code 1 at k+3, 2 at k+6, ..., 7 at k+21, 0 at k+24 with wrap = 1 for that one cycle only.
- dwell = 0, dir = 1, sweep = 1, code = 3, start -> codes 2,1,0 on consecutive clocks. Then 0 holds, done pulses once, busy falls, no wrap.
- IDLE, code = 7, dir = 0, pulse step -> code 0 next cycle, wrap = 1. start + step in the same cycle -> RUN entered, code unchanged that cycle.
- RUN with dwell = 4, assert start + stop together mid-dwell -> IDLE next cycle, code frozen, busy = 0. Repeat with rst_n = 0 mid-RUN -> code 000, IDLE.
- Connect to decoder_3_to_8_df with dwell = 0, sweep = 1, dir = 0 -> Y steps 00000001, 00000010, ..., 10000000 on consecutive clocks, then done.
